// File: rtl/memtest_stats_pkg.sv
// Shared constants and types for the memory-tester statistics block.
package memtest_stats_pkg;
  localparam int BCD_W       = 4;
  localparam int SEC_PER_MIN = 60;
  localparam int MAX_CH      = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;
endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD incrementer with sync clear and async reset; all-nines wraps to zero.
module bcd_counter
  import memtest_stats_pkg::*;
#(
  parameter int C_digits = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      inc,
  output logic [BCD_W*C_digits-1:0] value
);

  bcd_digit_t [C_digits-1:0] dig_q, dig_d;
  logic                      carry;

  // Ripple the increment upward; a digit that does not roll over absorbs the carry.
  always_comb begin
    dig_d = dig_q;
    carry = inc;
    for (int i = 0; i < C_digits; i++) begin
      if (carry) begin
        if (dig_q[i] == 4'd9) begin
          dig_d[i] = '0;
        end else begin
          dig_d[i] = dig_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      dig_q <= '0;
    else if (clear) dig_q <= '0;
    else            dig_q <= dig_d;
  end

  assign value = dig_q;

endmodule

// File: rtl/memtest_stats.sv
// Memory-tester statistics: elapsed BCD timer, per-channel pass/fail counters, sticky fail flag.
// Define MEMTEST_STATS_FIRSTFAIL_EN to compile in first-fail time/channel capture.
module memtest_stats
  import memtest_stats_pkg::*;
#(
  parameter int C_clk_hz   = 27500000,
  parameter int C_digits   = 4,
  parameter int C_channels = 1,
  parameter int C_cnt_bits = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             unit_min,
  input  logic [C_channels-1:0]            pass_pulse,
  input  logic [C_channels-1:0]            fail_pulse,
  output logic [BCD_W*C_digits-1:0]        elapsed_bcd,
  output logic                             tick,
  output logic [C_channels*C_cnt_bits-1:0] passcount,
  output logic [C_channels*C_cnt_bits-1:0] failcount,
  output logic                             fail_any,
  output logic [BCD_W*C_digits-1:0]        first_fail_bcd,
  output logic [1:0]                       first_fail_ch
);

  localparam int PW = $clog2(C_clk_hz);
  localparam int SW = $clog2(SEC_PER_MIN);

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          sec_stb, unit_stb;
  logic          tick_q, fail_any_q;

  assign sec_stb  = (presc_q == PW'(C_clk_hz - 1));
  assign unit_stb = unit_min ? (sec_stb && (sec_q == SW'(SEC_PER_MIN - 1))) : sec_stb;

  // Seconds keep running in both modes so switching units never loses phase.
  always_comb begin
    presc_d = sec_stb ? '0 : presc_q + PW'(1);
    sec_d   = sec_q;
    if (sec_stb) sec_d = (sec_q == SW'(SEC_PER_MIN - 1)) ? '0 : sec_q + SW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      sec_q      <= '0;
      tick_q     <= 1'b0;
      fail_any_q <= 1'b0;
    end else if (clear) begin
      presc_q    <= '0;
      sec_q      <= '0;
      tick_q     <= 1'b0;
      fail_any_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      tick_q     <= unit_stb;
      fail_any_q <= fail_any_q | (|fail_pulse);
    end
  end

  assign tick     = tick_q;
  assign fail_any = fail_any_q;

  bcd_counter #(.C_digits(C_digits)) u_elapsed (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (tick_q),
    .value (elapsed_bcd)
  );

  for (genvar g = 0; g < C_channels; g++) begin : g_ch
    logic [C_cnt_bits-1:0] pass_q, fail_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pass_q <= '0;
        fail_q <= '0;
      end else if (clear) begin
        pass_q <= '0;
        fail_q <= '0;
      end else begin
        if (pass_pulse[g] && (pass_q != '1)) pass_q <= pass_q + 1'b1;
        if (fail_pulse[g] && (fail_q != '1)) fail_q <= fail_q + 1'b1;
      end
    end

    assign passcount[g*C_cnt_bits +: C_cnt_bits] = pass_q;
    assign failcount[g*C_cnt_bits +: C_cnt_bits] = fail_q;
  end

`ifdef MEMTEST_STATS_FIRSTFAIL_EN
  logic [BCD_W*C_digits-1:0] ff_bcd_q;
  logic [1:0]                ff_ch_q;

  function automatic logic [1:0] low_idx(input logic [C_channels-1:0] v);
    low_idx = '0;
    for (int i = C_channels - 1; i >= 0; i--) if (v[i]) low_idx = 2'(i);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_bcd_q <= '0;
      ff_ch_q  <= '0;
    end else if (clear) begin
      ff_bcd_q <= '0;
      ff_ch_q  <= '0;
    end else if (!fail_any_q && (|fail_pulse)) begin
      ff_bcd_q <= elapsed_bcd;
      ff_ch_q  <= low_idx(fail_pulse);
    end
  end

  assign first_fail_bcd = ff_bcd_q;
  assign first_fail_ch  = ff_ch_q;
`else
  assign first_fail_bcd = '0;
  assign first_fail_ch  = '0;
`endif

endmodule
